// File: rtl/mdu_pkg.sv
// mdu_pkg: op/state encodings and constants shared by the multiply/divide unit.
package mdu_pkg;
   typedef enum logic [2:0] {
      MULT    = 3'd0,
      MULTU   = 3'd1,
      DIV     = 3'd2,
      DIVU    = 3'd3,
      MTHI    = 3'd4,
      MTLO    = 3'd5,
      OP_RSV6 = 3'd6,
      OP_RSV7 = 3'd7
   } mdu_op_t;
   typedef enum logic {IDLE, RUN} mdu_state_t;
   localparam int          MDU_ITER = 32;
   localparam logic [31:0] DIV0_LO  = 32'hFFFF_FFFF;
endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: unsigned restoring divider, one quotient bit per cycle; valid marks the final step.
module mdu_divider
   import mdu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        valid
);
   logic        active;
   logic [4:0]  cnt;
   logic [31:0] q, r, d;
   logic [32:0] trial;
   // quotient/remainder are the values after the step taken at the next edge
   assign trial     = {r, q[31]} - {1'b0, d};
   assign quotient  = {q[30:0], ~trial[32]};
   assign remainder = trial[32] ? {r[30:0], q[31]} : trial[31:0];
   assign valid     = active && cnt == 5'(MDU_ITER - 1);
   always_ff @(posedge clk) begin
      if (reset) begin
         active <= 1'b0;
         cnt    <= '0;
      end else if (load) begin
         active <= 1'b1;
         cnt    <= '0;
         q      <= dividend;
         r      <= '0;
         d      <= divisor;
      end else if (active) begin
         q      <= quotient;
         r      <= remainder;
         cnt    <= cnt + 5'd1;
         active <= !valid;
      end
   end
endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit owning the HI/LO registers.
// Define MDU_FAST_MULT_EN for single-cycle MULT/MULTU; divide stays iterative.
module mdu_hilo
   import mdu_pkg::*;
#(
   parameter int ITER_CYCLES = MDU_ITER
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  mdu_op_t     op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   mdu_state_t  state;
   mdu_op_t     op_q;
   logic [4:0]  cnt;
   logic        neg_q, neg_r, div0_q;
   logic [31:0] src_q, mplier, quot, rem, a_mag, b_mag, q_s, r_s;
   logic [63:0] acc, mcand, prod, prod_s;
   logic        is_mul, is_div, sgn, a_neg, b_neg, accept, div_valid, last;
   assign is_mul = op == MULT || op == MULTU;
   assign is_div = op == DIV || op == DIVU;
   assign sgn    = op == MULT || op == DIV;
   assign a_neg  = sgn & rs_data[31];
   assign b_neg  = sgn & rt_data[31];
   assign a_mag  = a_neg ? -rs_data : rs_data;
   assign b_mag  = b_neg ? -rt_data : rt_data;
   assign accept = start && state == IDLE;
   assign busy   = state == RUN;
   assign prod   = acc + (mplier[0] ? mcand : 64'd0);
   assign prod_s = neg_q ? -prod : prod;
   assign q_s    = neg_q ? -quot : quot;
   assign r_s    = neg_r ? -rem : rem;
   assign last   = (op_q == DIV || op_q == DIVU) ? div_valid : cnt == 5'(ITER_CYCLES - 1);
`ifdef MDU_FAST_MULT_EN
   logic [63:0] fast_p, fast_s;
   assign fast_p = 64'(a_mag) * 64'(b_mag);
   assign fast_s = (a_neg ^ b_neg) ? -fast_p : fast_p;
`endif
   mdu_divider u_div (
      .clk       (clk),
      .reset     (reset),
      .load      (accept && is_div),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .quotient  (quot),
      .remainder (rem),
      .valid     (div_valid)
   );
   // Operand capture runs every idle cycle; only the accepting edge's copy is consumed in RUN.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         done  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            op_q   <= op;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            div0_q <= rt_data == '0;
            src_q  <= rs_data;
            acc    <= '0;
            mcand  <= {32'd0, a_mag};
            mplier <= b_mag;
            cnt    <= '0;
            if (start && op == MTHI) hi <= rs_data;
            if (start && op == MTLO) lo <= rs_data;
            if (start && (op == MTHI || op == MTLO)) done <= 1'b1;
`ifdef MDU_FAST_MULT_EN
            if (start && is_mul) begin
               {hi, lo} <= fast_s;
               done     <= 1'b1;
            end
            if (start && is_div) state <= RUN;
`else
            if (start && (is_mul || is_div)) state <= RUN;
`endif
         end else begin
            cnt    <= cnt + 5'd1;
            acc    <= prod;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (last) begin
               state    <= IDLE;
               done     <= 1'b1;
               {hi, lo} <= (op_q == MULT || op_q == MULTU) ? prod_s :
                           div0_q ? {src_q, DIV0_LO} : {r_s, q_s};
            end
         end
      end
   end
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: random and directed stimulus checked every cycle against an arithmetic reference model.
module tb_mdu_hilo;
   import mdu_pkg::*;
`ifdef MDU_FAST_MULT_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif
   localparam int MUL_LAT = FAST ? 0 : MDU_ITER;
   logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
   mdu_op_t     op = MULT;
   logic [31:0] rs_data = '0, rt_data = '0;
   logic        busy, done;
   logic [31:0] hi, lo;
   int          tests = 0, fails = 0;
   bit          chk = 1'b0;
   logic [31:0] m_hi, m_lo, p_hi, p_lo;
   logic        m_busy, m_done;
   int          m_left;

   mdu_hilo dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // {hi,lo} an op must produce, straight from the arithmetic definition
   function automatic logic [63:0] ref_result(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = '0;
      case (o)
         MULT:  p = longint'(int'(a)) * longint'(int'(b));
         MULTU: p = {32'd0, a} * {32'd0, b};
         DIV:   if (b == 0) p = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'd0, 32'h8000_0000};
                else p = {32'(int'(a) % int'(b)), 32'(int'(a) / int'(b))};
         DIVU:  if (b == 0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
         default: p = '0;
      endcase
      return p;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
      end else begin
         m_done = 1'b0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               {m_hi, m_lo} = {p_hi, p_lo};
               m_busy = 1'b0;
               m_done = 1'b1;
            end
         end else if (start) begin
            {p_hi, p_lo} = ref_result(op, rs_data, rt_data);
            if (op == MTHI) begin m_hi = rs_data; m_done = 1'b1; end
            else if (op == MTLO) begin m_lo = rs_data; m_done = 1'b1; end
            else if ((op == MULT || op == MULTU) && FAST) begin {m_hi, m_lo} = {p_hi, p_lo}; m_done = 1'b1; end
            else if (op inside {MULT, MULTU, DIV, DIVU}) begin m_left = MDU_ITER; m_busy = 1'b1; end
         end
      end
   end

   always @(negedge clk) begin
      if (chk) begin
         check("model hi", hi, m_hi);
         check("model lo", lo, m_lo);
         check("model busy", busy, m_busy);
         check("model done", done, m_done);
      end
   end

   task automatic issue(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1; op = o; rs_data = a; rt_data = b;
      @(posedge clk); #2;
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 100) begin @(posedge clk); #2; n++; end
      check("done before timeout", done, 1'b1);
   endtask

   task automatic run(input string name, input mdu_op_t o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ehi, input logic [31:0] elo, input bit ebusy, input int elat);
      int n;
      issue(o, a, b);
      check({name, " busy"}, busy, ebusy);
      wait_done(n);
      check({name, " latency"}, n, elat);
      check({name, " hi"}, hi, ehi);
      check({name, " lo"}, lo, elo);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom % 6)
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom % 16);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int nd;
      start = 1'b1; op = MTHI; rs_data = 32'h5;
      repeat (2) @(posedge clk);
      #1;
      chk = 1'b1;
      check("reset hi", hi, 32'd0);
      check("reset lo", lo, 32'd0);
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      #1;
      reset = 1'b0; start = 1'b0;
      @(posedge clk); #2;
      run("multu max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, !FAST, MUL_LAT);
      run("mult -3x7", MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, !FAST, MUL_LAT);
      run("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, MDU_ITER);
      run("divu 7/0", DIVU, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1, MDU_ITER);
      run("div min/-1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b1, MDU_ITER);
      issue(OP_RSV6, 32'h1234, 32'h5678);
      check("rsv op done", done, 1'b0);
      check("rsv op lo", lo, 32'h8000_0000);
      start = 1'b1; op = MTHI; rs_data = 32'h1234_5678;
      @(posedge clk); #2;
      check("mthi done", done, 1'b1);
      check("mthi hi", hi, 32'h1234_5678);
      op = MTLO; rs_data = 32'h9ABC_DEF0;
      @(posedge clk); #2;
      start = 1'b0;
      check("mtlo done", done, 1'b1);
      check("mtlo lo", lo, 32'h9ABC_DEF0);
      check("mtlo hi kept", hi, 32'h1234_5678);
      @(posedge clk); #2;
      check("mt done drops", done, 1'b0);
      issue(DIVU, 32'd100, 32'd7);
      repeat (5) begin @(posedge clk); #2; end
      issue(MTHI, 32'h0000_DEAD, 32'd0);
      wait_done(nd);
      check("mthi in run hi", hi, 32'd2);
      check("mthi in run lo", lo, 32'd14);
      @(posedge clk); #2;
      issue(DIVU, 32'd100, 32'd7);
      repeat (9) begin @(posedge clk); #2; end
      reset = 1'b1;
      @(posedge clk); #2;
      reset = 1'b0;
      check("abort busy", busy, 1'b0);
      check("abort hi", hi, 32'd0);
      check("abort lo", lo, 32'd0);
      check("abort done", done, 1'b0);
      nd = 0;
      repeat (40) begin @(posedge clk); #2; if (done) nd++; end
      check("abort no done", nd, 0);
      run("divu 100/7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, MDU_ITER);
      repeat (3000) begin
         reset   = ($urandom % 500) == 0;
         start   = ($urandom % 3) == 0;
         op      = mdu_op_t'(3'($urandom));
         rs_data = pick();
         rt_data = pick();
         @(posedge clk); #2;
      end
      reset = 1'b0; start = 1'b0;
      repeat (40) begin @(posedge clk); #2; end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
